// File: rtl/servo_pwm_generator.sv
// ---------------------------------------------------------------------------
// servo_pwm_generator
//
// Purpose:
//   Produces the 50 Hz servo drive waveform (MG995) from a 2-bit angle
//   select. Each period is exactly PERIOD_CYCLES_P clocks: a high pulse of
//   the applied width followed by a low gap. Width and enable are only
//   re-evaluated at a period boundary (or while idle), so a pulse is never
//   truncated or stretched by a mid-period input change.
//
// Ports:
//   Clk_i           in   1          system clock
//   Reset_i         in   1          synchronous, active-low reset
//   Enable_i        in   1          1 = run; sampled in IDLE and at the boundary
//   Sel_i           in   2          0 = no output, 1/2/3 = 0/90/180 deg
//   Pwm_o           out  1          registered servo drive
//   Period_Start_o  out  1          one-cycle pulse on the first high cycle
//   Width_o         out  WIDTH_W_P  width applied in the current period, 0 idle
//
// Configuration:
//   SERVO_PWM_RAMP_EN  when defined, consecutive periods move the applied
//                      width toward the selected target by at most
//                      RAMP_STEP_P per period. Leaving IDLE always loads the
//                      target directly. When undefined the target is applied
//                      at every boundary and no ramp logic exists.
//
// States:
//   state | meaning
//   IDLE  | output low, waiting for Enable_i=1 with Sel_i!=0
//   PULSE | output high, counter 0 .. width-1
//   GAP   | output low, counter width .. PERIOD_CYCLES_P-1 (last = boundary)
// ---------------------------------------------------------------------------
module servo_pwm_generator #(
  parameter int PERIOD_CYCLES_P = 1000000,
  parameter int PERIOD_CNT_W_P  = 20,
  parameter int WIDTH_W_P       = 17,
  parameter int ANGLE_0_P       = 25000,
  parameter int ANGLE_90_P      = 75000,
  parameter int ANGLE_180_P     = 125000,
  parameter int RAMP_STEP_P     = 500
) (
  input  logic                 Clk_i,
  input  logic                 Reset_i,
  input  logic                 Enable_i,
  input  logic [1:0]           Sel_i,
  output logic                 Pwm_o,
  output logic                 Period_Start_o,
  output logic [WIDTH_W_P-1:0] Width_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [PERIOD_CNT_W_P-1:0] CNT_LAST = PERIOD_CNT_W_P'(PERIOD_CYCLES_P - 1);
  localparam logic [PERIOD_CNT_W_P-1:0] CNT_ONE  = PERIOD_CNT_W_P'(1);
  localparam logic [WIDTH_W_P-1:0]      W_ANG_0   = WIDTH_W_P'(ANGLE_0_P);
  localparam logic [WIDTH_W_P-1:0]      W_ANG_90  = WIDTH_W_P'(ANGLE_90_P);
  localparam logic [WIDTH_W_P-1:0]      W_ANG_180 = WIDTH_W_P'(ANGLE_180_P);

  state_t                     state_q, state_d;
  logic [PERIOD_CNT_W_P-1:0]  cnt_q, cnt_d;
  logic [WIDTH_W_P-1:0]       width_q, width_d;
  logic                       pwm_q, pwm_d;
  logic                       pstart_q, pstart_d;

  logic [WIDTH_W_P-1:0]       target;
  logic [WIDTH_W_P-1:0]       next_width;
  logic                       start_ok;
  logic                       pulse_last;

  // Decode of the angle select into a high-time in clock cycles.
  always_comb begin
    target = '0;
    case (Sel_i)
      2'd1:    target = W_ANG_0;
      2'd2:    target = W_ANG_90;
      2'd3:    target = W_ANG_180;
      default: target = '0;
    endcase
  end

  assign start_ok = Enable_i && (Sel_i != 2'd0);

  // Last high cycle of the pulse: counter == width-1. Compared at 32 bits so
  // the counter and width fields may differ in size.
  assign pulse_last = ((32'(cnt_q) + 32'd1) == 32'(width_q));

`ifdef SERVO_PWM_RAMP_EN
  localparam logic [WIDTH_W_P-1:0] W_STEP = WIDTH_W_P'(RAMP_STEP_P);

  // Step toward the target; the difference is only formed in the direction
  // that cannot wrap.
  always_comb begin
    next_width = target;
    if (target > width_q) begin
      if ((target - width_q) > W_STEP) begin
        next_width = width_q + W_STEP;
      end
    end else begin
      if ((width_q - target) > W_STEP) begin
        next_width = width_q - W_STEP;
      end
    end
  end
`else
  assign next_width = target;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    width_d  = width_q;
    pwm_d    = pwm_q;
    pstart_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        width_d = '0;
        pwm_d   = 1'b0;
        if (start_ok) begin
          state_d  = ST_PULSE;
          width_d  = target;
          pwm_d    = 1'b1;
          pstart_d = 1'b1;
        end
      end
      ST_PULSE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (pulse_last) begin
          state_d = ST_GAP;
          pwm_d   = 1'b0;
        end else begin
          pwm_d = 1'b1;
        end
      end
      ST_GAP: begin
        pwm_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (start_ok) begin
            // Back-to-back period: no idle cycle in between.
            state_d  = ST_PULSE;
            width_d  = next_width;
            pwm_d    = 1'b1;
            pstart_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            width_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        width_d = '0;
        pwm_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      width_q  <= '0;
      pwm_q    <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      pwm_q    <= pwm_d;
      pstart_q <= pstart_d;
    end
  end

  assign Pwm_o          = pwm_q;
  assign Period_Start_o = pstart_q;
  assign Width_o        = width_q;

endmodule

// File: tb/tb_servo_pwm_generator.sv
module tb_servo_pwm_generator;

  localparam int P     = 200;
  localparam int CW    = 8;
  localparam int WW    = 8;
  localparam int A0    = 1;
  localparam int A90   = 15;
  localparam int A180  = 199;
  localparam int STEP  = 40;

  logic          Clk_i = 1'b0;
  logic          Reset_i = 1'b0;
  logic          Enable_i = 1'b0;
  logic [1:0]    Sel_i = 2'd0;
  logic          Pwm_o;
  logic          Period_Start_o;
  logic [WW-1:0] Width_o;

  int errors = 0;
  int checks = 0;

  servo_pwm_generator #(
    .PERIOD_CYCLES_P(P), .PERIOD_CNT_W_P(CW), .WIDTH_W_P(WW),
    .ANGLE_0_P(A0), .ANGLE_90_P(A90), .ANGLE_180_P(A180), .RAMP_STEP_P(STEP)
  ) dut (
    .Clk_i(Clk_i), .Reset_i(Reset_i), .Enable_i(Enable_i), .Sel_i(Sel_i),
    .Pwm_o(Pwm_o), .Period_Start_o(Period_Start_o), .Width_o(Width_o)
  );

  always #5 Clk_i = ~Clk_i;

  // Reference model: a period is "running" with a phase (cycles since its
  // first high cycle) and a width; output is high while phase < width.
  bit m_run = 1'b0;
  int m_phase = 0;
  int m_w = 0;
  bit m_start = 1'b0;

  function automatic int angle_of(logic [1:0] s);
    int tbl [4] = '{0, A0, A90, A180};
    return tbl[s];
  endfunction

  function automatic int ramp_to(int cur, int tgt);
    int d = tgt - cur;
    if (d > STEP) return cur + STEP;
    if (d < -STEP) return cur - STEP;
    return tgt;
  endfunction

  always @(posedge Clk_i) begin
    if (!Reset_i) begin
      m_run = 1'b0; m_phase = 0; m_w = 0; m_start = 1'b0;
    end else if (!m_run || m_phase == P - 1) begin
      if (Enable_i && Sel_i != 2'd0) begin
`ifdef SERVO_PWM_RAMP_EN
        m_w = m_run ? ramp_to(m_w, angle_of(Sel_i)) : angle_of(Sel_i);
`else
        m_w = angle_of(Sel_i);
`endif
        m_run = 1'b1; m_phase = 0; m_start = 1'b1;
      end else begin
        m_run = 1'b0; m_phase = 0; m_w = 0; m_start = 1'b0;
      end
    end else begin
      m_phase = m_phase + 1;
      m_start = 1'b0;
    end
  end

  task automatic step();
    logic          exp_pwm;
    logic          exp_ps;
    logic [WW-1:0] exp_w;
    @(negedge Clk_i);
    exp_pwm = (m_run && m_phase < m_w) ? 1'b1 : 1'b0;
    exp_ps  = m_start;
    exp_w   = WW'(m_w);
    checks++;
    assert (Pwm_o === exp_pwm) else begin
      errors++;
      $error("FAIL pwm t=%0t got %b exp %b", $time, Pwm_o, exp_pwm);
    end
    checks++;
    assert (Period_Start_o === exp_ps) else begin
      errors++;
      $error("FAIL period_start t=%0t got %b exp %b", $time, Period_Start_o, exp_ps);
    end
    checks++;
    assert (Width_o === exp_w) else begin
      errors++;
      $error("FAIL width t=%0t got %0d exp %0d", $time, Width_o, exp_w);
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int hi_cnt;
    // Reset state
    run(3);
    Reset_i = 1'b1;
    run(4);

    // Steady 90 deg running, including the high-count over one full period
    Enable_i = 1'b1; Sel_i = 2'd2;
    step();
    hi_cnt = 0;
    for (int i = 0; i < P; i++) begin
      step();
      if (Pwm_o === 1'b1) hi_cnt++;
    end
    checks++;
    assert (hi_cnt === A90) else begin
      errors++;
      $error("FAIL high_count got %0d exp %0d", hi_cnt, A90);
    end
    run(P);

    // Select change mid-pulse applies next period only
    run(7);
    Sel_i = 2'd3;
    run(2 * P);

    // Drop enable mid-pulse: period completes, then idle
    Sel_i = 2'd2;
    run(P);
    Enable_i = 1'b0;
    run(2 * P);

    // Reset during pulse, restart at 0 deg (width 1 boundary)
    Enable_i = 1'b1; Sel_i = 2'd2;
    run(5);
    Reset_i = 1'b0; Sel_i = 2'd1;
    run(3);
    Reset_i = 1'b1;
    run(2 * P + 10);

    // Enabled but no angle selected
    Sel_i = 2'd0;
    run(3 * P);

    // Large step up (ramped when the option is built), then back down
    Sel_i = 2'd1;
    run(2 * P);
    Sel_i = 2'd3;
    run(7 * P);
    Sel_i = 2'd1;
    run(7 * P);

    // Randomized input sequences with occasional resets
    for (int k = 0; k < 40; k++) begin
      Enable_i = ($urandom_range(0, 3) != 0);
      Sel_i    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        Reset_i = 1'b0;
        run($urandom_range(1, 3));
        Reset_i = 1'b1;
      end
      run($urandom_range(1, 2 * P));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
